keypad_scan: RTL and testbench
==============================

KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clk cycles each column is driven before its rows are sampled (1 ms at 50 MHz).
REQ-002 Parameter DEB_CYC, default 1000000: clk cycles of stable input needed to accept a press or a release (20 ms at 50 MHz).
REQ-003 clk  input  1  single system clock; all logic on posedge.
REQ-004 RSTn  input  1  synchronous, active-high reset (the name is kept for codebase consistency; high = reset).
REQ-005 row  input  4  keypad row lines, pulled up, active-low, asynchronous.
REQ-006 col  output  4  keypad column drive, active-low, exactly one bit low at all times.
REQ-007 onehot  output  16  debounced key code, bit (4*row_idx + col_idx); 16'h0000 = no key; feeds onehot2binary.
REQ-008 key_pulse  output  1  one-cycle strobe on the cycle onehot changes from zero to non-zero.

Function
REQ-009 row SHALL pass through a 2-flop synchronizer (rs); all decisions use rs, never row directly.
REQ-010 States: SCAN, DEBOUNCE, PRESSED, RELEASE.
REQ-011 SCAN: col_idx 0->1->2->3->0, advancing every SCAN_DIV cycles; col = ~(4'b0001 << col_idx).
REQ-012 SCAN: rs is sampled only on the last dwell cycle of each column. Exactly one bit low -> latch row_idx and col_idx, clear the counter, go to DEBOUNCE, freeze col. Zero bits low or two or more bits low -> no capture, advance the column.
REQ-013 DEBOUNCE: counter increments while rs equals the latched pattern. Any mismatch -> go to SCAN at the next column, with onehot unchanged (0).
REQ-014 DEBOUNCE: on the cycle the counter reaches DEB_CYC-1 with rs still matching -> go to PRESSED. Registered on that edge: onehot <= 1 << (4*row_idx + col_idx) and key_pulse <= 1.
REQ-015 PRESSED: onehot held constant and col frozen. rs != latched pattern (all-high or any other pattern) -> clear the counter and go to RELEASE.
REQ-016 RELEASE: counter increments while rs == 4'b1111. Any low bit -> return to PRESSED, with onehot unchanged.
REQ-017 RELEASE: counter reaching DEB_CYC-1 with rs all-high -> onehot <= 0, go to SCAN, col_idx advances by 1 (mod 4).
REQ-018 key_pulse SHALL be high for exactly one cycle per accepted press and SHALL NOT fire on release.
REQ-019 onehot SHALL have at most one bit set, and SHALL only move between 0 and a one-hot value, never directly between two keys.
REQ-020 Counters SHALL be sized to $clog2 of their limit and SHALL wrap only through explicit clear, never by overflow.
REQ-021 Minimum press-to-onehot latency: DEB_CYC cycles after capture, plus 2 synchronizer cycles, plus up to 4*SCAN_DIV scan cycles.

Reset
REQ-022 RSTn high at a clock edge sets: state=SCAN, col_idx=0, col=4'b1110, onehot=16'h0000, key_pulse=0, all counters=0, synchronizer flops=4'b1111.
REQ-023 Reset asserted mid-press (in any state) SHALL force the reset values on the next edge. A key still held after reset deasserts SHALL be re-detected through the full SCAN/DEBOUNCE path.

Structure
REQ-024 Package keypad_pkg SHALL hold the state typedef (SCAN, DEBOUNCE, PRESSED, RELEASE), the default SCAN_DIV and DEB_CYC values, and the NO_KEY = 16'h0000 constant.
REQ-025 Sub-module sync2 (4-bit, 2-flop synchronizer, reset value all-ones) SHALL be instantiated once for row; everything else is in keypad_scan.

Verification (bench params SCAN_DIV=4, DEB_CYC=8)
REQ-026 Reset check: after reset, col cycles 1110 -> 1101 -> 1011 -> 0111 every 4 clocks, with onehot=0 and key_pulse=0 throughout.
REQ-027 Single press: row=1101 while col=1011 (row1, col2), held 40 cycles -> onehot=16'h0040 and one key_pulse. Then row=1111 held 20 cycles -> onehot returns to 0 after 8 stable cycles.
REQ-028 Bounce: row toggles 1110/1111 every 3 cycles on col0 for 30 cycles -> onehot stays 0 and key_pulse never asserts.
REQ-029 Release bounce: key row3/col3 accepted (onehot=16'h8000), then 5 cycles high, 2 low, 10 high -> onehot holds 8000 until the 8-cycle high run completes, then goes to 0; no second key_pulse.
REQ-030 Ghost/multi-key: row=1100 on any column -> no capture, scan continues, onehot=0.
REQ-031 Reset mid-press: RSTn pulsed 1 cycle while onehot=16'h0001 and the key stays held -> onehot=0 the next cycle, then 16'h0001 again with a fresh key_pulse after re-debounce.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types, defaults and small helpers for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } kp_state_t;

  localparam int          DEF_SCAN_DIV = 50000;
  localparam int          DEF_DEB_CYC  = 1000000;
  localparam logic [15:0] NO_KEY       = 16'h0000;

  // True when exactly one of the active-low row lines is pulled low.
  function automatic logic single_low(input logic [3:0] v);
    logic [3:0] a;
    a = ~v;
    return (a != 4'd0) && ((a & (a - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] v);
    logic [1:0] idx;
    case (v)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  function automatic logic [15:0] key_code(input logic [1:0] r, input logic [1:0] c);
    return 16'd1 << {r, c};
  endfunction

  function automatic logic [3:0] col_drive(input logic [1:0] c);
    return ~(4'b0001 << c);
  endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Keypad pins plus decoded key outputs; master is the keypad/host side.
interface keypad_scan_if;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [15:0] onehot;
  logic        key_pulse;

  modport master (output row, input col, input onehot, input key_pulse);
  modport slave  (input row, output col, output onehot, output key_pulse);
endinterface

// File: rtl/keypad_scan_sync2.sv
// Two-flop synchronizer for the asynchronous keypad row lines; idles all-ones.
module sync2 #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta_r;
  logic [W-1:0] q_r;

  // Two-stage capture chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= {W{1'b1}};
      q_r    <= {W{1'b1}};
    end else begin
      meta_r <= d;
      q_r    <= meta_r;
    end
  end

  assign q = q_r;
endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad column scanner with press/release debouncing and one-hot key output.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = DEF_SCAN_DIV,
  parameter int DEB_CYC  = DEF_DEB_CYC
) (
  input logic          clk,
  input logic          RSTn,
  keypad_scan_if.slave kp
);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYC - 1);

  logic [3:0]    rs_s;
  kp_state_t     state_r, state_nxt;
  logic [1:0]    col_idx_r, col_idx_nxt;
  logic [3:0]    col_r, col_nxt;
  logic [SW-1:0] div_r, div_nxt;
  logic [DW-1:0] deb_r, deb_nxt;
  logic [3:0]    pat_r, pat_nxt;
  logic [1:0]    row_idx_r, row_idx_nxt;
  logic [15:0]   onehot_r, onehot_nxt;
  logic          pulse_r, pulse_nxt;

  sync2 #(.W(4)) u_sync (
    .clk (clk),
    .rst (RSTn),
    .d   (kp.row),
    .q   (rs_s)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (RSTn) begin
      state_r   <= SCAN;
      col_idx_r <= 2'd0;
      col_r     <= 4'b1110;
      div_r     <= '0;
      deb_r     <= '0;
      pat_r     <= 4'b1111;
      row_idx_r <= 2'd0;
      onehot_r  <= NO_KEY;
      pulse_r   <= 1'b0;
    end else begin
      state_r   <= state_nxt;
      col_idx_r <= col_idx_nxt;
      col_r     <= col_nxt;
      div_r     <= div_nxt;
      deb_r     <= deb_nxt;
      pat_r     <= pat_nxt;
      row_idx_r <= row_idx_nxt;
      onehot_r  <= onehot_nxt;
      pulse_r   <= pulse_nxt;
    end
  end

  // Next-state and output decode; col stays frozen outside SCAN.
  always_comb begin
    state_nxt   = state_r;
    col_idx_nxt = col_idx_r;
    div_nxt     = div_r;
    deb_nxt     = deb_r;
    pat_nxt     = pat_r;
    row_idx_nxt = row_idx_r;
    onehot_nxt  = onehot_r;
    pulse_nxt   = 1'b0;

    case (state_r)
      SCAN: begin
        if (div_r == SCAN_LAST) begin
          div_nxt = '0;
          if (single_low(rs_s)) begin
            state_nxt   = DEBOUNCE;
            pat_nxt     = rs_s;
            row_idx_nxt = low_index(rs_s);
            deb_nxt     = '0;
          end else begin
            col_idx_nxt = col_idx_r + 2'd1;
          end
        end else begin
          div_nxt = div_r + SW'(1);
        end
      end
      DEBOUNCE: begin
        if (rs_s != pat_r) begin
          state_nxt   = SCAN;
          col_idx_nxt = col_idx_r + 2'd1;
          div_nxt     = '0;
        end else if (deb_r == DEB_LAST) begin
          state_nxt  = PRESSED;
          onehot_nxt = key_code(row_idx_r, col_idx_r);
          pulse_nxt  = 1'b1;
        end else begin
          deb_nxt = deb_r + DW'(1);
        end
      end
      PRESSED: begin
        if (rs_s != pat_r) begin
          state_nxt = RELEASE;
          deb_nxt   = '0;
        end else begin
          state_nxt = PRESSED;
        end
      end
      RELEASE: begin
        // Any low line, even a different key, falls back to the held state.
        if (rs_s != 4'b1111) begin
          state_nxt = PRESSED;
        end else if (deb_r == DEB_LAST) begin
          state_nxt   = SCAN;
          onehot_nxt  = NO_KEY;
          col_idx_nxt = col_idx_r + 2'd1;
          div_nxt     = '0;
          deb_nxt     = '0;
        end else begin
          deb_nxt = deb_r + DW'(1);
        end
      end
      default: begin
        state_nxt   = SCAN;
        col_idx_nxt = 2'd0;
        div_nxt     = '0;
        deb_nxt     = '0;
        onehot_nxt  = NO_KEY;
      end
    endcase

    col_nxt = col_drive(col_idx_nxt);
  end

  assign kp.col       = col_r;
  assign kp.onehot    = onehot_r;
  assign kp.key_pulse = pulse_r;
endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a per-cycle behavioural reference model.
module tb_keypad_scan;
  import keypad_pkg::*;

  localparam int SD = 4;
  localparam int DC = 8;

  logic clk = 1'b0;
  logic RSTn;
  keypad_scan_if kp ();

  keypad_scan #(.SCAN_DIV(SD), .DEB_CYC(DC)) dut (
    .clk  (clk),
    .RSTn (RSTn),
    .kp   (kp)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: rows seen through a 2-cycle delay, a column pointer that
  // dwells SD cycles, and run lengths of stable samples for press/release.
  logic [3:0]  q1, q2, m_pat;
  int          m_col, m_dwell, m_mode, m_run, m_key;
  logic [15:0] m_onehot;
  logic        m_pulse;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    logic [3:0] r;
    int lo;
    r  = q2;
    q2 = q1;
    q1 = kp.row;
    if (RSTn) begin
      q1 = 4'hF; q2 = 4'hF;
      m_col = 0; m_dwell = 0; m_mode = 0; m_run = 0;
      m_onehot = 16'h0000; m_pulse = 1'b0; m_valid = 1'b1;
    end else if (m_valid) begin
      m_pulse = 1'b0;
      if (m_mode == 0) begin
        m_dwell++;
        if (m_dwell == SD) begin
          m_dwell = 0;
          if ($countones(~r) == 1) begin
            lo = 0;
            for (int i = 0; i < 4; i++) if (!r[i]) lo = i;
            m_mode = 1; m_pat = r; m_run = 0; m_key = 4 * lo + m_col;
          end else begin
            m_col = (m_col + 1) % 4;
          end
        end
      end else if (m_mode == 1) begin
        if (r != m_pat) begin
          m_mode = 0; m_col = (m_col + 1) % 4; m_dwell = 0;
        end else begin
          m_run++;
          if (m_run == DC) begin
            m_mode = 2; m_onehot = 16'd1 << m_key; m_pulse = 1'b1;
          end
        end
      end else if (m_mode == 2) begin
        if (r != m_pat) begin
          m_mode = 3; m_run = 0;
        end
      end else begin
        if (r != 4'hF) begin
          m_mode = 2;
        end else begin
          m_run++;
          if (m_run == DC) begin
            m_mode = 0; m_onehot = 16'h0000; m_col = (m_col + 1) % 4; m_dwell = 0;
          end
        end
      end
    end
  end

  // Compare DUT against the model on every cycle, mid-period.
  always @(negedge clk) begin
    logic [3:0] ec;
    if (m_valid) begin
      ec = ~(4'b0001 << m_col);
      chk("col", 32'(kp.col), 32'(ec));
      chk("onehot", 32'(kp.onehot), 32'(m_onehot));
      chk("key_pulse", 32'(kp.key_pulse), 32'(m_pulse));
      chk("onehot_single", 32'($countones(kp.onehot) <= 1), 32'd1);
      if (kp.key_pulse === 1'b1) pulses++;
    end
  end

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_col(input logic [3:0] c, input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (kp.col != c) begin found = 1'b1; break; end
      hold(1);
    end
    if (found) begin
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
        if (kp.col == c) begin found = 1'b1; break; end
        hold(1);
      end
    end
    chk(name, 32'(found), 32'd1);
  endtask

  task automatic wait_key(input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (kp.onehot != 16'h0000) begin found = 1'b1; break; end
      hold(1);
    end
    chk(name, 32'(found), 32'd1);
  endtask

  logic [3:0] seq [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  initial begin
    int p0;
    logic [3:0] c0;
    RSTn   = 1'b1;
    kp.row = 4'hF;
    repeat (3) @(posedge clk);
    #1 RSTn = 1'b0;

    // Reset state and free-running scan.
    for (int k = 0; k < 8; k++) begin
      chk("reset_col", 32'(kp.col), 32'(seq[k % 4]));
      chk("reset_onehot", 32'(kp.onehot), 32'h0);
      hold(4);
    end
    chk("reset_no_pulse", 32'(pulses), 32'd0);

    // Single press row1/col2 then clean release.
    p0 = pulses;
    wait_col(4'b1011, "press_wait");
    kp.row = 4'b1101;
    hold(40);
    chk("press_onehot", 32'(kp.onehot), 32'h0040);
    chk("press_pulse", 32'(pulses - p0), 32'd1);
    kp.row = 4'hF;
    hold(20);
    chk("release_onehot", 32'(kp.onehot), 32'h0);
    chk("release_no_pulse", 32'(pulses - p0), 32'd1);

    // Contact bounce shorter than the debounce window.
    p0 = pulses;
    wait_col(4'b1110, "bounce_wait");
    for (int i = 0; i < 10; i++) begin
      kp.row = (i % 2 == 0) ? 4'b1110 : 4'b1111;
      hold(3);
    end
    kp.row = 4'hF;
    hold(6);
    chk("bounce_onehot", 32'(kp.onehot), 32'h0);
    chk("bounce_pulse", 32'(pulses - p0), 32'd0);

    // Release bounce on row3/col3.
    p0 = pulses;
    wait_col(4'b0111, "rb_wait");
    kp.row = 4'b0111;
    hold(20);
    chk("rb_press", 32'(kp.onehot), 32'h8000);
    kp.row = 4'hF;
    hold(5);
    kp.row = 4'b0111;
    hold(2);
    chk("rb_hold1", 32'(kp.onehot), 32'h8000);
    kp.row = 4'hF;
    hold(10);
    chk("rb_hold2", 32'(kp.onehot), 32'h8000);
    hold(1);
    chk("rb_clear", 32'(kp.onehot), 32'h0);
    chk("rb_pulse", 32'(pulses - p0), 32'd1);

    // Two rows low: ghosting, never captured.
    p0 = pulses;
    kp.row = 4'b1100;
    hold(20);
    chk("ghost_onehot", 32'(kp.onehot), 32'h0);
    c0 = kp.col;
    hold(4);
    chk("ghost_advance", 32'(kp.col != c0), 32'd1);
    chk("ghost_pulse", 32'(pulses - p0), 32'd0);
    kp.row = 4'hF;
    hold(4);

    // Reset while a key is held, then re-detection.
    p0 = pulses;
    wait_col(4'b1110, "mp_wait");
    kp.row = 4'b1110;
    wait_key("mp_first_timeout");
    hold(2);
    chk("mp_press", 32'(kp.onehot), 32'h0001);
    chk("mp_pulse", 32'(pulses - p0), 32'd1);
    RSTn = 1'b1;
    hold(1);
    RSTn = 1'b0;
    chk("mp_reset_onehot", 32'(kp.onehot), 32'h0);
    chk("mp_reset_col", 32'(kp.col), 32'(4'b1110));
    p0 = pulses;
    wait_key("mp_again_timeout");
    hold(2);
    chk("mp_again", 32'(kp.onehot), 32'h0001);
    chk("mp_again_pulse", 32'(pulses - p0), 32'd1);

    kp.row = 4'hF;
    hold(20);
    chk("final_onehot", 32'(kp.onehot), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
